alu_serial_ctrl: RTL and testbench
==================================

Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that drives the 1-bit ALU slice as its initiator. It accepts WIDTH-bit operands and an opcode, presents one bit pair per cycle LSB-first, and feeds the slice's carry-out back into carry-in. It collects the result bits and reports the final word and carry. It sits between the datapath/control unit and a single combinational ALU slice.

Parameters:
WIDTH, 8, operand/result word width in bits (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted when busy=0
a  in  WIDTH  operand A, sampled on accepted start
b  in  WIDTH  operand B, sampled on accepted start
carry_in  in  1  initial carry for ALU_ADDC, sampled on accepted start
opcode  in  3  word operation, ALU_* encoding (ADD, AND, NOT, ADDC, XOR, SUB)
busy  out  1  high while bits are being sequenced
done  out  1  one-cycle pulse; result/carry_out valid from this cycle
result  out  WIDTH  assembled word, held until next accepted start
carry_out  out  1  final carry (arithmetic ops), else 0
alu_op_a  out  1  bit to slice op_a
alu_op_b  out  1  bit to slice op_b
alu_cin  out  1  carry to slice cin
alu_opcode  out  3  opcode to slice
alu_result  in  1  slice result (combinational from alu_* outputs)
alu_cout  in  1  slice carry out

Behaviour:
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: busy=0, done=0, result=0, carry_out=0, internal shift registers/counter/carry=0; alu_op_a/op_b/cin=0, alu_opcode=0.
- Accept: start=1 while state is IDLE or DONE. Latch a, b, opcode and carry_in. Counter=0. Go to RUN. start in RUN is ignored and has no side effects.
- Opcode mapping to the slice, fixed for the whole word:
  - ADD: slice ALU_ADDC, initial carry 0.
  - ADDC: slice ALU_ADDC, initial carry = latched carry_in.
  - SUB: slice ALU_ADDC, op_b bits inverted, initial carry 1 (two's complement).
  - AND/XOR/NOT: same opcode passed through, alu_cin=0, carry not updated.
  - Undefined codes (6,7): passed through. The slice returns 0, so result=0 and carry_out=0. Still takes WIDTH cycles.
- RUN, each cycle k=0..WIDTH-1:
  - alu_op_a = A[k] and alu_op_b = B[k] (or ~B[k] for SUB), both from the LSB of registered shift registers.
  - alu_cin = carry register.
  - On the clock edge, alu_result is shifted into result bit k. For arithmetic ops, carry register <= alu_cout.
- busy=1 exactly in RUN, which lasts WIDTH cycles. The ALU-side outputs are 0 outside RUN.
- After the k=WIDTH-1 edge: state=DONE, done=1 for one cycle, carry_out = carry register for arithmetic ops, else 0.
- Latency: start accepted at edge 0; done high in the cycle after edge WIDTH. No stall input.
- DONE → IDLE next cycle unless start=1, in which case DONE → RUN (back-to-back, no bubble).
- result/carry_out are stable from done until the edge that accepts the next start. On that edge they are cleared to 0.
- SUB carry_out: 1 = no borrow (a>=b unsigned), 0 = borrow.
- rst_n low at any time, including mid-RUN: immediate return to reset values. A partial result is discarded and done is not pulsed.

Test Plan:
- WIDTH=8, ADD a=0xC8 b=0x64 → busy for 8 cycles, done in cycle 9 after start, result=0x2C, carry_out=1; alu_opcode=ALU_ADDC throughout RUN.
- SUB a=0x05 b=0x07 → result=0xFE, carry_out=0; SUB a=0x07 b=0x05 → result=0x02, carry_out=1.
- ADDC a=0xFF b=0x00 carry_in=1 → result=0x00, carry_out=1; same with carry_in=0 → result=0xFF, carry_out=0.
- Logic ops: NOT a=0xA5 → 0x5A; AND 0xF0,0x3C → 0x30; XOR 0xF0,0x3C → 0xCC. carry_out=0 and alu_cin=0 throughout all three.
- start pulsed during RUN with different operands → ignored, original result produced; start held on the done cycle → next RUN begins the following cycle, second result correct.
- rst_n low at RUN cycle 4 → busy/done/result/alu_* go 0 asynchronously, no done pulse; a fresh ADD 0x01+0x01 afterwards → 0x02, carry_out=0.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial initiator for a 1-bit combinational ALU slice: streams a WIDTH-bit op LSB-first.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH (busy for WIDTH cycles).
// Backpressure: none; start is only taken in IDLE/DONE, ignored while RUN (no stall input).
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [2:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             alu_op_a,
    output logic             alu_op_b,
    output logic             alu_cin,
    output logic [2:0]       alu_opcode,
    input  logic             alu_result,
    input  logic             alu_cout
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_ADDC = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SUB  = 3'd5;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [2:0]       slice_op_q;
    logic             arith_q;
    logic             carry_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q;
    logic             done_q;

    logic             accept;
    logic             last_bit;
    logic [2:0]       slice_op_d;
    logic             arith_d;
    logic [WIDTH-1:0] b_eff_d;
    logic             carry_init_d;

    assign accept   = start && (state_q != S_RUN);
    assign last_bit = (cnt_q == LAST_IDX);

    // Map the word opcode onto a fixed slice opcode, operand-B polarity and initial carry.
    // All arithmetic rides on the slice's ADDC; SUB is a + ~b + 1.
    always_comb begin
        slice_op_d   = opcode;
        arith_d      = 1'b0;
        b_eff_d      = b;
        carry_init_d = 1'b0;
        case (opcode)
            ALU_ADD: begin
                slice_op_d = ALU_ADDC;
                arith_d    = 1'b1;
            end
            ALU_ADDC: begin
                slice_op_d   = ALU_ADDC;
                arith_d      = 1'b1;
                carry_init_d = carry_in;
            end
            ALU_SUB: begin
                slice_op_d   = ALU_ADDC;
                arith_d      = 1'b1;
                b_eff_d      = ~b;
                carry_init_d = 1'b1;
            end
            ALU_AND, ALU_NOT, ALU_XOR: slice_op_d = opcode;
            default:                   slice_op_d = opcode;
        endcase
    end

    // Sequencer FSM: load operands on accept, shift one bit pair per cycle, then report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            slice_op_q  <= '0;
            arith_q     <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q     <= S_RUN;
                cnt_q       <= '0;
                a_sh_q      <= a;
                b_sh_q      <= b_eff_d;
                slice_op_q  <= slice_op_d;
                arith_q     <= arith_d;
                carry_q     <= carry_init_d;
                result_q    <= '0;
                carry_out_q <= 1'b0;
            end else begin
                case (state_q)
                    S_RUN: begin
                        a_sh_q   <= a_sh_q >> 1;
                        b_sh_q   <= b_sh_q >> 1;
                        result_q <= {alu_result, result_q[WIDTH-1:1]};
                        cnt_q    <= cnt_q + 1'b1;
                        if (arith_q) begin
                            carry_q <= alu_cout;
                        end
                        if (last_bit) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            carry_out_q <= arith_q & alu_cout;
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy       = (state_q == S_RUN);
    assign done       = done_q;
    assign result     = result_q;
    assign carry_out  = carry_out_q;
    // Slice-side drive is forced low outside RUN so the slice sees a quiet bus.
    assign alu_op_a   = busy & a_sh_q[0];
    assign alu_op_b   = busy & b_sh_q[0];
    assign alu_cin    = busy & carry_q;
    assign alu_opcode = busy ? slice_op_q : 3'b000;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural 1-bit ALU slice attached.
// Latency: expects done exactly WIDTH cycles after the accepting edge.
// Backpressure: exercises ignored start in RUN and back-to-back start on the done cycle.
module tb_alu_serial_ctrl;

    localparam int WIDTH = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_ADDC = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [2:0]       opcode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             alu_op_a;
    logic             alu_op_b;
    logic             alu_cin;
    logic [2:0]       alu_opcode;
    logic             alu_result;
    logic             alu_cout;

    int n_checks = 0;
    int n_errors = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .carry_in   (carry_in),
        .opcode     (opcode),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .alu_op_a   (alu_op_a),
        .alu_op_b   (alu_op_b),
        .alu_cin    (alu_cin),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit slice: ADDC is a full adder, logic ops per bit, anything else returns 0.
    always_comb begin
        alu_result = 1'b0;
        alu_cout   = 1'b0;
        case (alu_opcode)
            OP_ADDC: {alu_cout, alu_result} = {1'b0, alu_op_a} + {1'b0, alu_op_b} + {1'b0, alu_cin};
            OP_AND:  alu_result = alu_op_a & alu_op_b;
            OP_NOT:  alu_result = ~alu_op_a;
            OP_XOR:  alu_result = alu_op_a ^ alu_op_b;
            default: alu_result = 1'b0;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge; returns at the negedge of RUN cycle 0.
    task automatic launch(input logic [2:0] op, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cin);
        opcode   = op;
        a        = av;
        b        = bv;
        carry_in = cin;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Follow RUN bit by bit, then check latency, result and carry on the done cycle.
    task automatic wait_check(input string tag, input logic [2:0] op,
                              input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input logic [WIDTH-1:0] exp_res, input logic exp_c,
                              input bit poke_start);
        logic [WIDTH-1:0] b_eff;
        logic [2:0]       exp_slice;
        bit               is_logic;
        int               cyc;
        b_eff     = (op == OP_SUB) ? ~bv : bv;
        exp_slice = (op == OP_ADD || op == OP_SUB || op == OP_ADDC) ? OP_ADDC : op;
        is_logic  = (exp_slice != OP_ADDC);
        cyc = 0;
        while (!done && cyc < 4 * WIDTH) begin
            check_val({tag, " busy"}, {31'd0, busy}, 32'd1);
            check_val({tag, " alu_opcode"}, {29'd0, alu_opcode}, {29'd0, exp_slice});
            if (cyc < WIDTH) begin
                check_val({tag, " alu_op_a"}, {31'd0, alu_op_a}, {31'd0, av[cyc]});
                check_val({tag, " alu_op_b"}, {31'd0, alu_op_b}, {31'd0, b_eff[cyc]});
            end
            if (is_logic) check_val({tag, " alu_cin"}, {31'd0, alu_cin}, 32'd0);
            if (poke_start && cyc == 3) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
            end
            if (poke_start && cyc == 4) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check_val({tag, " latency"}, cyc, WIDTH);
        check_val({tag, " done"}, {31'd0, done}, 32'd1);
        check_val({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check_val({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
        check_val({tag, " carry_out"}, {31'd0, carry_out}, {31'd0, exp_c});
        check_val({tag, " alu_opcode_idle"}, {29'd0, alu_opcode}, 32'd0);
    endtask

    // Single op from idle, plus a check that done drops and results hold.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic cin,
                          input logic [WIDTH-1:0] exp_res, input logic exp_c);
        launch(op, av, bv, cin);
        wait_check(tag, op, av, bv, exp_res, exp_c, 1'b0);
        @(negedge clk);
        check_val({tag, " done_pulse"}, {31'd0, done}, 32'd0);
        check_val({tag, " result_hold"}, {24'd0, result}, {24'd0, exp_res});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        opcode   = '0;
        #12;
        check_val("rst busy", {31'd0, busy}, 32'd0);
        check_val("rst done", {31'd0, done}, 32'd0);
        check_val("rst result", {24'd0, result}, 32'd0);
        check_val("rst carry_out", {31'd0, carry_out}, 32'd0);
        check_val("rst alu_bits", {29'd0, alu_op_a, alu_op_b, alu_cin}, 32'd0);
        check_val("rst alu_opcode", {29'd0, alu_opcode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add",     OP_ADD,  8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);
        run_op("sub_b",   OP_SUB,  8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
        run_op("sub_nb",  OP_SUB,  8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
        run_op("addc1",   OP_ADDC, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        run_op("addc0",   OP_ADDC, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
        run_op("add_cin", OP_ADD,  8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0);
        run_op("not",     OP_NOT,  8'hA5, 8'h00, 1'b1, 8'h5A, 1'b0);
        run_op("and",     OP_AND,  8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0);
        run_op("xor",     OP_XOR,  8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0);
        run_op("undef6",  3'd6,    8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0);

        // start pulsed mid-RUN with different operands must be ignored
        launch(OP_ADD, 8'h12, 8'h34, 1'b0);
        wait_check("ignore", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
        @(negedge clk);

        // back-to-back: start held on the done cycle
        launch(OP_ADD, 8'h0F, 8'h01, 1'b0);
        wait_check("b2b_1", OP_ADD, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        launch(OP_XOR, 8'hAA, 8'h55, 1'b0);
        check_val("b2b busy", {31'd0, busy}, 32'd1);
        check_val("b2b cleared", {24'd0, result}, 32'd0);
        wait_check("b2b_2", OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);

        // reset in the middle of RUN
        launch(OP_ADD, 8'hFF, 8'hFF, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst done", {31'd0, done}, 32'd0);
        check_val("mid_rst result", {24'd0, result}, 32'd0);
        check_val("mid_rst alu_bits", {29'd0, alu_op_a, alu_op_b, alu_cin}, 32'd0);
        check_val("mid_rst alu_opcode", {29'd0, alu_opcode}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check_val("mid_rst no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (WIDTH + 2) begin
            @(negedge clk);
            check_val("post_rst no_done", {31'd0, done}, 32'd0);
        end
        run_op("post_rst_add", OP_ADD, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
